// File: rtl/baud_sel_ctrl.sv
// Baud-rate select controller: auto-baud measurement on a 0x55 sync character or manual
// rate writes, applied while the transmitter is idle. Optional macro: BAUD_SEL_RX_SYNC_EN.
module baud_sel_ctrl #(
    parameter int CNT_W   = 16,
    parameter int MIN_CNT = 434,
    parameter int MAX_CNT = 20834,
    parameter int T_115K2 = 1302,
    parameter int T_57K6  = 2170,
    parameter int T_38K4  = 3906,
    parameter int T_19K2  = 7812
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       start,
    input  logic       cfg_wr,
    input  logic [2:0] cfg_sel,
    input  logic       tx_busy,
    output logic [2:0] select,
    output logic       gen_rst,
    output logic       busy,
    output logic       locked,
    output logic       err
);

    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] T1_W  = CNT_W'(T_115K2);
    localparam logic [CNT_W-1:0] T2_W  = CNT_W'(T_57K6);
    localparam logic [CNT_W-1:0] T3_W  = CNT_W'(T_38K4);
    localparam logic [CNT_W-1:0] T4_W  = CNT_W'(T_19K2);
    localparam logic [CNT_W-1:0] ONE_W = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_HIGH = 4'd1,
        S_WAIT_FALL = 4'd2,
        S_LOW1      = 4'd3,
        S_HIGH1     = 4'd4,
        S_LOW2      = 4'd5,
        S_CHECK     = 4'd6,
        S_PEND      = 4'd7,
        S_APPLY     = 4'd8
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, w1_r, w1_s, w2_r, w2_s;
    logic [2:0]       code_r, code_s, select_r, select_s;
    logic             gen_rst_r, gen_rst_s, busy_r, busy_s;
    logic             locked_r, locked_s, err_r, err_s;
    logic             rx_s, timeout_s, cfg_ok_s, check_ok_s;
    logic [3:0]       cls1_s, cls2_s;

    // Map a pulse width to {valid, code}; equality with a threshold falls to the slower code.
    function automatic logic [3:0] classify(input logic [CNT_W-1:0] w);
        logic [3:0] r;
        if ((w < MIN_W) || (w > MAX_W)) begin
            r = 4'b0000;
        end else if (w < T1_W) begin
            r = 4'b1100;
        end else if (w < T2_W) begin
            r = 4'b1011;
        end else if (w < T3_W) begin
            r = 4'b1010;
        end else if (w < T4_W) begin
            r = 4'b1001;
        end else begin
            r = 4'b1000;
        end
        return r;
    endfunction

`ifdef BAUD_SEL_RX_SYNC_EN
    logic [1:0] rx_sync_r;

    // Two-flop synchronizer, idles high like the line itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx};
        end
    end
    assign rx_s = rx_sync_r[1];
`else
    assign rx_s = rx;
`endif

    // Continuing the same level at MAX_CNT would push the count past the limit.
    assign timeout_s  = (cnt_r >= MAX_W);
    assign cfg_ok_s   = (cfg_sel <= 3'b100);
    assign cls1_s     = classify(w1_r);
    assign cls2_s     = classify(w2_r);
    assign check_ok_s = cls1_s[3] && cls2_s[3] && (cls1_s[2:0] == cls2_s[2:0]);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            w1_r      <= '0;
            w2_r      <= '0;
            code_r    <= 3'b000;
            select_r  <= 3'b000;
            gen_rst_r <= 1'b0;
            busy_r    <= 1'b0;
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            w1_r      <= w1_s;
            w2_r      <= w2_s;
            code_r    <= code_s;
            select_r  <= select_s;
            gen_rst_r <= gen_rst_s;
            busy_r    <= busy_s;
            locked_r  <= locked_s;
            err_r     <= err_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_WAIT_HIGH;
                end else if (cfg_wr && cfg_ok_s) begin
                    state_s = S_PEND;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT_HIGH: state_s = rx_s ? S_WAIT_FALL : S_WAIT_HIGH;
            S_WAIT_FALL: state_s = rx_s ? S_WAIT_FALL : S_LOW1;
            S_LOW1: begin
                if (rx_s) begin
                    state_s = S_HIGH1;
                end else if (timeout_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_LOW1;
                end
            end
            S_HIGH1: begin
                if (!rx_s) begin
                    state_s = S_LOW2;
                end else if (timeout_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_HIGH1;
                end
            end
            S_LOW2: begin
                if (rx_s) begin
                    state_s = S_CHECK;
                end else if (timeout_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_LOW2;
                end
            end
            S_CHECK: state_s = check_ok_s ? S_PEND : S_IDLE;
            S_PEND:  state_s = tx_busy ? S_PEND : S_APPLY;
            S_APPLY: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_s     = cnt_r;
        w1_s      = w1_r;
        w2_s      = w2_r;
        code_s    = code_r;
        select_s  = select_r;
        gen_rst_s = 1'b0;
        busy_s    = busy_r;
        locked_s  = locked_r;
        err_s     = err_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    busy_s   = 1'b1;
                    locked_s = 1'b0;
                    err_s    = 1'b0;
                end else if (cfg_wr && cfg_ok_s) begin
                    code_s   = cfg_sel;
                    busy_s   = 1'b1;
                    locked_s = 1'b0;
                    err_s    = 1'b0;
                end else if (cfg_wr) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            S_WAIT_HIGH: cnt_s = '0;
            S_WAIT_FALL: cnt_s = rx_s ? cnt_r : ONE_W;
            S_LOW1: begin
                if (rx_s) begin
                    w1_s  = cnt_r;
                    cnt_s = ONE_W;
                end else if (timeout_s) begin
                    err_s  = 1'b1;
                    busy_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + ONE_W;
                end
            end
            S_HIGH1: begin
                if (!rx_s) begin
                    cnt_s = ONE_W;
                end else if (timeout_s) begin
                    err_s  = 1'b1;
                    busy_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + ONE_W;
                end
            end
            S_LOW2: begin
                if (rx_s) begin
                    w2_s = cnt_r;
                end else if (timeout_s) begin
                    err_s  = 1'b1;
                    busy_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + ONE_W;
                end
            end
            S_CHECK: begin
                if (check_ok_s) begin
                    code_s = cls1_s[2:0];
                end else begin
                    err_s  = 1'b1;
                    busy_s = 1'b0;
                end
            end
            S_PEND: begin
                if (!tx_busy) begin
                    select_s  = code_r;
                    gen_rst_s = 1'b1;
                end else begin
                    select_s = select_r;
                end
            end
            S_APPLY: begin
                locked_s = 1'b1;
                busy_s   = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign select  = select_r;
    assign gen_rst = gen_rst_r;
    assign busy    = busy_r;
    assign locked  = locked_r;
    assign err     = err_r;

endmodule

// File: tb/tb_baud_sel_ctrl.sv
// Randomized self-checking bench for baud_sel_ctrl against a pulse-width level model.
module tb_baud_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       start = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_sel = 3'b000;
    logic       tx_busy = 1'b0;
    logic [2:0] select;
    logic       gen_rst, busy, locked, err;

    int n_chk = 0;
    int n_fail = 0;
    int gen_total = 0;
    int gen_wide = 0;
    int sel_bad = 0;
    logic       prev_gen = 1'b0;
    logic [2:0] prev_sel = 3'b000;

    // Expected architectural state.
    int exp_sel = 0;
    int exp_locked = 0;
    int exp_err = 0;

    baud_sel_ctrl dut (
        .clk(clk), .rst(rst), .rx(rx), .start(start), .cfg_wr(cfg_wr),
        .cfg_sel(cfg_sel), .tx_busy(tx_busy), .select(select), .gen_rst(gen_rst),
        .busy(busy), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Rate code for a width, -1 when the width is a glitch or too long.
    function automatic int rate_of(input int w);
        if (w < 434 || w > 20834) return -1;
        if (w < 1302) return 4;
        if (w < 2170) return 3;
        if (w < 3906) return 2;
        if (w < 7812) return 1;
        return 0;
    endfunction

    // gen_rst pulse accounting and select-stability watch.
    always @(negedge clk) begin
        if (gen_rst) gen_total <= gen_total + 1;
        if (gen_rst && prev_gen) gen_wide <= gen_wide + 1;
        if (!rst && (select !== prev_sel) && !gen_rst) sel_bad <= sel_bad + 1;
        prev_gen <= gen_rst;
        prev_sel <= select;
    end

    task automatic check_state(input string tag);
        chk({tag, "_sel"}, 32'(select), 32'(exp_sel));
        chk({tag, "_locked"}, 32'(locked), 32'(exp_locked));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_auto(input string tag, input int w1, input int h, input int w2,
                            input int txb, input bit inj);
        int  c1, c2, g0, seen, exp_off;
        bit  ok;
        c1 = rate_of(w1);
        c2 = rate_of(w2);
        ok = (c1 >= 0) && (c1 == c2);
        exp_off = ok ? ((txb + 1 > 3) ? txb + 1 : 3) : 0;
        g0 = gen_total;
        @(negedge clk);
        start = 1'b1;
        tx_busy = (txb > 0);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        rx = 1'b0;
        repeat (w1) @(negedge clk);
        rx = 1'b1;
        if (inj) begin
            @(negedge clk);
            cfg_wr = 1'b1; cfg_sel = 3'b001; start = 1'b1;
            @(negedge clk);
            cfg_wr = 1'b0; start = 1'b0;
            repeat (h - 2) @(negedge clk);
        end else begin
            repeat (h) @(negedge clk);
        end
        rx = 1'b0;
        repeat (w2) @(negedge clk);
        rx = 1'b1;
        seen = 0;
        for (int i = 1; i <= txb + 40; i++) begin
            @(negedge clk);
            if (gen_rst && seen == 0) seen = i;
            if (i == txb) tx_busy = 1'b0;
        end
        tx_busy = 1'b0;
        chk({tag, "_gen_offset"}, 32'(seen), 32'(exp_off));
        chk({tag, "_gen_count"}, 32'(gen_total - g0), ok ? 32'd1 : 32'd0);
        if (ok) begin
            exp_sel = c1; exp_locked = 1; exp_err = 0;
        end else begin
            exp_locked = 0; exp_err = 1;
        end
        check_state(tag);
    endtask

    task automatic man_wr(input string tag, input logic [2:0] sel);
        int g0;
        bit ok;
        ok = (sel <= 3'b100);
        g0 = gen_total;
        @(negedge clk);
        cfg_wr = 1'b1; cfg_sel = sel;
        @(negedge clk);
        cfg_wr = 1'b0;
        repeat (6) @(negedge clk);
        chk({tag, "_gen_count"}, 32'(gen_total - g0), ok ? 32'd1 : 32'd0);
        if (ok) begin
            exp_sel = int'(sel); exp_locked = 1; exp_err = 0;
        end else begin
            exp_err = 1;
        end
        check_state(tag);
    endtask

    task automatic run_timeout();
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b0;
        n = 0;
        for (int i = 1; i <= 21000; i++) begin
            @(negedge clk);
            n = i;
            if (!busy) break;
        end
        rx = 1'b1;
        chk("timeout_cycle", 32'(n), 32'd20835);
        exp_locked = 0; exp_err = 1;
        repeat (4) @(negedge clk);
        check_state("timeout");
    endtask

    initial begin
        int w1, h, w2, txb;
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset_gen", 32'(gen_rst), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_state("idle");

        run_auto("b115k", 868, 868, 868, 0, 1'b0);
        run_auto("b19k_txbusy", 5208, 5208, 5208, 300, 1'b0);
        run_auto("mismatch", 868, 868, 2604, 0, 1'b0);
        run_auto("glitch", 200, 868, 868, 0, 1'b0);
        run_auto("thr_eq", 1302, 1302, 1302, 0, 1'b0);
        run_auto("min_edge", 434, 600, 434, 0, 1'b0);
        run_auto("below_min", 433, 600, 433, 0, 1'b0);
        run_timeout();

        man_wr("man_011", 3'b011);
        man_wr("man_110", 3'b110);
        run_auto("inj_cfg", 868, 868, 868, 3, 1'b1);

        for (int k = 0; k < 5; k++) begin
            w1 = $urandom_range(300, 1500);
            h = $urandom_range(300, 1500);
            w2 = ($urandom_range(0, 1) == 0) ? w1 : $urandom_range(300, 1500);
            txb = $urandom_range(0, 20);
            run_auto($sformatf("rnd%0d", k), w1, h, w2, txb, 1'b0);
            if ($urandom_range(0, 1) == 1) man_wr($sformatf("rnd_man%0d", k), 3'($urandom_range(0, 7)));
        end

        // Reset in the middle of a measurement discards everything.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        exp_sel = 0; exp_locked = 0; exp_err = 0;
        check_state("mid_reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        chk("gen_width", 32'(gen_wide), 32'd0);
        chk("select_stable", 32'(sel_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
